// File: rtl/vga_rect_fill.sv
// vga_rect_fill
//   Bus-programmed rectangle filler for a 1-bit frame buffer. The processor
//   writes the rectangle corners X0/Y0/X1/Y1 and then a command byte. The
//   block clips the rectangle to the frame buffer, writes one pixel per cycle
//   in raster order, and pulses an interrupt when the fill has finished.
//
//   Register map (BaseAddress + n):
//     +0 X0, +1 Y0, +2 X1, +3 Y1   read/write
//     +4 write: command {bit7 abort, bit1 START, bit0 colour}
//        read:  status  {7'b0, BUSY}
//   Reads are registered: BUS_DATA is driven on the cycle after the request.
//
//   Ports:
//     CLK        system clock; all logic runs on the rising edge
//     RESET      synchronous reset, active high
//     BUS_ADDR   processor bus address
//     BUS_DATA   processor bus data (tri-state, driven only for reads)
//     BUS_WE     processor bus write strobe
//     FB_ADDR    frame-buffer address {Y[6:0], X[7:0]}
//     FB_DATA    pixel value written
//     FB_WE      frame-buffer write enable, one pixel per cycle
//     DONE_IRQ   one-cycle pulse when a fill completes
//
//   Build option:
//     VGA_FILL_ABORT_EN  when defined, a command write with bit7 set is
//                        accepted while busy and ends the current fill early.
module vga_rect_fill #(
  parameter logic [7:0]  BaseAddress = 8'hB8,
  parameter int unsigned FbWidth     = 160,
  parameter int unsigned FbHeight    = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  inout  logic [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic        DONE_IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] XMax = 8'(FbWidth - 1);
  localparam logic [7:0] YMax = 8'(FbHeight - 1);

  state_t state_q, state_d;

  // Processor-visible coordinate registers
  logic [7:0] x0_q, x0_d;
  logic [7:0] y0_q, y0_d;
  logic [7:0] x1_q, x1_d;
  logic [7:0] y1_q, y1_d;

  // Working registers captured at START (already clipped)
  logic [7:0] wx0_q, wx0_d;
  logic [7:0] wx1_q, wx1_d;
  logic [6:0] wy1_q, wy1_d;
  logic [7:0] cur_x_q, cur_x_d;
  logic [6:0] cur_y_q, cur_y_d;
  logic       colour_q, colour_d;

  // Registered read port
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_data_q, rd_data_d;

  // Bus decode
  logic [7:0] offset;
  logic       hit;
  logic       busy;
  logic       wr_en;
  logic       cmd_hit;
  logic       start;
  logic       abort;

  // Clipping
  logic [7:0] cx1;
  logic [7:0] cy1;
  logic       empty;
  logic       last_pixel;

  // Subtracting the base makes the range test a single unsigned compare.
  assign offset  = BUS_ADDR - BaseAddress;
  assign hit     = (offset < 8'd5);
  assign busy    = (state_q != IDLE);
  assign wr_en   = hit && BUS_WE && !busy;
  assign cmd_hit = hit && BUS_WE && (offset == 8'd4);
  assign start   = wr_en && (offset == 8'd4) && BUS_DATA[1];

`ifdef VGA_FILL_ABORT_EN
  assign abort = cmd_hit && BUS_DATA[7] && (state_q == FILL);
`else
  assign abort = 1'b0;
`endif

  assign cx1 = (x1_q > XMax) ? XMax : x1_q;
  assign cy1 = (y1_q > YMax) ? YMax : y1_q;

  assign empty = (32'(x0_q) >= FbWidth) || (32'(y0_q) >= FbHeight) ||
                 (x0_q > cx1) || (y0_q > cy1);

  assign last_pixel = (cur_x_q == wx1_q) && (cur_y_q == wy1_q);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = empty ? DONE : FILL;
        end
      end
      FILL: begin
        if (abort || last_pixel) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; FB address/data come straight from the raster registers so
  // they naturally hold their last value whenever FB_WE is low.
  always_comb begin
    FB_WE    = (state_q == FILL);
    DONE_IRQ = (state_q == DONE);
    FB_ADDR  = {cur_y_q, cur_x_q};
    FB_DATA  = colour_q;
  end

  // Register file, raster walker and read port
  always_comb begin
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    wx0_d     = wx0_q;
    wx1_d     = wx1_q;
    wy1_d     = wy1_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    colour_d  = colour_q;
    rd_en_d   = hit && !BUS_WE;
    rd_data_d = '0;

    if (wr_en) begin
      case (offset)
        8'd0:    x0_d = BUS_DATA;
        8'd1:    y0_d = BUS_DATA;
        8'd2:    x1_d = BUS_DATA;
        8'd3:    y1_d = BUS_DATA;
        default: ;
      endcase
    end

    // An empty rectangle leaves the raster registers alone so FB_ADDR and
    // FB_DATA keep showing the last pixel actually written.
    if (start && !empty) begin
      wx0_d    = x0_q;
      wx1_d    = cx1;
      wy1_d    = cy1[6:0];
      cur_x_d  = x0_q;
      cur_y_d  = y0_q[6:0];
      colour_d = BUS_DATA[0];
    end else if ((state_q == FILL) && !last_pixel && !abort) begin
      if (cur_x_q == wx1_q) begin
        cur_x_d = wx0_q;
        cur_y_d = cur_y_q + 7'd1;
      end else begin
        cur_x_d = cur_x_q + 8'd1;
      end
    end

    case (offset)
      8'd0:    rd_data_d = x0_q;
      8'd1:    rd_data_d = y0_q;
      8'd2:    rd_data_d = x1_q;
      8'd3:    rd_data_d = y1_q;
      8'd4:    rd_data_d = {7'b0, busy};
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      wx0_q     <= '0;
      wx1_q     <= '0;
      wy1_q     <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      colour_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      wx0_q     <= wx0_d;
      wx1_q     <= wx1_d;
      wy1_q     <= wy1_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      colour_q  <= colour_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 'z;

endmodule
